// File: rtl/sui_simd_regs_reader.sv
// Stack-upstream side of the SIMD result handoff: waits for all lanes valid, snapshots them,
// pulses complete back to SIMD, then streams header + lane words over valid/ready.
module sui_simd_regs_reader #(
  parameter int NUM_LANES   = 32,
  parameter int LANE_WIDTH  = 32,
  parameter int PE_ID_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic [PE_ID_WIDTH-1:0]          peId,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] simd__sui__regs,
  input  logic [NUM_LANES-1:0]            simd__sui__regs_valid,
  output logic                            sui__simd__regs_complete,
  output logic                            sui__up_valid,
  output logic [LANE_WIDTH-1:0]           sui__up_data,
  output logic                            sui__up_sop,
  output logic                            sui__up_eop,
  input  logic                            up__sui_ready
);

  localparam int          PTR_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [7:0]  LANE_CNT = 8'(NUM_LANES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {IDLE, CMPL, HDR, DATA} state_e;

  state_e                  state_q, state_d;
  logic [LANE_WIDTH-1:0]   snap_q [NUM_LANES];
  logic [LANE_WIDTH-1:0]   snap_d [NUM_LANES];
  logic [PE_ID_WIDTH-1:0]  peid_snap_q, peid_snap_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d, ptr_nxt;
  logic [7:0]              seq_q, seq_d;
  logic                    complete_q, complete_d;
  logic                    valid_q, valid_d;
  logic                    sop_q, sop_d;
  logic                    eop_q, eop_d;
  logic [LANE_WIDTH-1:0]   data_q, data_d, hdr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    peid_snap_d = peid_snap_q;
    ptr_d       = ptr_q;
    seq_d       = seq_q;
    complete_d  = 1'b0;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    data_d      = data_q;
    ptr_nxt     = ptr_q + 1'b1;

    hdr = '0;
    hdr[LANE_WIDTH-1 -: PE_ID_WIDTH] = peid_snap_q;
    hdr[15:8] = seq_q;
    hdr[7:0]  = LANE_CNT;

    unique case (state_q)
      IDLE: begin
        if (&simd__sui__regs_valid) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            snap_d[i] = simd__sui__regs[i*LANE_WIDTH +: LANE_WIDTH];
          end
          peid_snap_d = peId;
          complete_d  = 1'b1;
          state_d     = CMPL;
        end
      end
      CMPL: begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        eop_d   = 1'b0;
        data_d  = hdr;
        state_d = HDR;
      end
      HDR: begin
        if (up__sui_ready) begin
          ptr_d   = '0;
          sop_d   = 1'b0;
          eop_d   = (NUM_LANES == 1);
          data_d  = snap_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (up__sui_ready) begin
          if (eop_q) begin
            valid_d = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
          end else begin
            // Outputs are registered, so the word after ptr is loaded on this accept.
            ptr_d  = ptr_nxt;
            data_d = snap_q[ptr_nxt];
            eop_d  = (ptr_nxt == LAST_PTR);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the snapshot array is reset too, so nothing stale can leak into a word after power-on.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q     <= IDLE;
      snap_q      <= '{default: '0};
      peid_snap_q <= '0;
      ptr_q       <= '0;
      seq_q       <= '0;
      complete_q  <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      peid_snap_q <= peid_snap_d;
      ptr_q       <= ptr_d;
      seq_q       <= seq_d;
      complete_q  <= complete_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= data_d;
    end
  end

  assign sui__simd__regs_complete = complete_q;
  assign sui__up_valid            = valid_q;
  assign sui__up_data             = data_q;
  assign sui__up_sop              = sop_q;
  assign sui__up_eop              = eop_q;

endmodule

// File: tb/tb_sui_simd_regs_reader.sv
// Directed bench for sui_simd_regs_reader: capture trigger, packet format, stalls, snapshot
// isolation, sequence wrap and asynchronous reset mid-packet.
module tb_sui_simd_regs_reader;

  localparam int NL = 32;
  localparam int LW = 32;

  logic              clk = 1'b0;
  logic              reset_poweron = 1'b1;
  logic [7:0]        peId = 8'h5A;
  logic [NL*LW-1:0]  regs = '0;
  logic [NL-1:0]     regs_valid = '0;
  logic              complete;
  logic              up_valid;
  logic [LW-1:0]     up_data;
  logic              up_sop;
  logic              up_eop;
  logic              up_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cmpl_cnt = 0;

  sui_simd_regs_reader #(.NUM_LANES(NL), .LANE_WIDTH(LW), .PE_ID_WIDTH(8)) dut (
    .clk                      (clk),
    .reset_poweron            (reset_poweron),
    .peId                     (peId),
    .simd__sui__regs          (regs),
    .simd__sui__regs_valid    (regs_valid),
    .sui__simd__regs_complete (complete),
    .sui__up_valid            (up_valid),
    .sui__up_data             (up_data),
    .sui__up_sop              (up_sop),
    .sui__up_eop              (up_eop),
    .up__sui_ready            (up_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (complete) cmpl_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [31:0] base);
    for (int i = 0; i < NL; i++) regs[i*LW +: LW] = base + 32'(i);
  endtask

  // Raise all-valid, wait for the complete pulse, act as the SIMD side clearing valid, and
  // optionally overwrite lane results. Returns in the first cycle the header is visible.
  task automatic trigger(input bit scramble);
    int n = 0;
    regs_valid = '1;
    do begin
      tick();
      n++;
    end while (!complete && n < 20);
    check("cmpl_latency", 64'(n), 64'd1);
    regs_valid = '0;
    if (scramble) set_regs(32'h5555_0000);
    tick();
    check("cmpl_one_cycle", 64'(complete), 64'd0);
  endtask

  task automatic recv_pkt(input logic [7:0] exp_seq, input logic [31:0] base, input bit rand_rdy);
    int idx = 0;
    int cycles = 0;
    int bubbles = 0;
    bit started = 1'b0;
    bit stalled = 1'b0;
    logic [34:0] held = '0;
    logic [31:0] exp_word;
    while (idx <= NL && cycles < 2000) begin
      if (stalled) check("stall_hold", 64'({up_valid, up_sop, up_eop, up_data}), 64'(held));
      up_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (up_valid) begin
        started = 1'b1;
        if (up_ready) begin
          exp_word = (idx == 0) ? {8'h5A, 8'h00, exp_seq, 8'h20} : base + 32'(idx - 1);
          check("word", 64'(up_data), 64'(exp_word));
          check("sop", 64'(up_sop), 64'(idx == 0));
          check("eop", 64'(up_eop), 64'(idx == NL));
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {up_valid, up_sop, up_eop, up_data};
        end
      end else if (started) begin
        bubbles++;
      end
      tick();
      cycles++;
    end
    check("pkt_words", 64'(idx), 64'(NL + 1));
    if (!rand_rdy) begin
      check("no_bubble", 64'(bubbles), 64'd0);
      check("contig_cycles", 64'(cycles), 64'(NL + 1));
    end
    check("idle_after_eop", 64'(up_valid), 64'd0);
    up_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    #2;
    check("rst_valid", 64'(up_valid), 64'd0);
    check("rst_cmpl", 64'(complete), 64'd0);
    tick();
    reset_poweron = 1'b0;
    tick();
  endtask

  initial begin
    int base_cnt;
    set_regs(32'hA000_0000);

    #3;
    check("rst_valid0", 64'(up_valid), 64'd0);
    check("rst_data0", 64'(up_data), 64'd0);
    check("rst_sop_eop0", 64'({up_sop, up_eop}), 64'd0);
    check("rst_cmpl0", 64'(complete), 64'd0);
    tick();
    reset_poweron = 1'b0;
    tick();

    // Lanes 0..30 valid only: nothing may happen.
    regs_valid = 32'h7FFF_FFFF;
    for (int i = 0; i < 6; i++) tick();
    check("partial_no_cmpl", 64'(cmpl_cnt), 64'd0);
    check("partial_no_valid", 64'(up_valid), 64'd0);

    up_ready = 1'b1;
    trigger(1'b0);
    check("hdr_valid", 64'(up_valid), 64'd1);
    check("hdr_sop", 64'(up_sop), 64'd1);
    check("hdr_data", 64'(up_data), 64'h5A00_0020);
    recv_pkt(8'd0, 32'hA000_0000, 1'b0);

    trigger(1'b0);
    recv_pkt(8'd1, 32'hA000_0000, 1'b1);

    trigger(1'b1);
    recv_pkt(8'd2, 32'hA000_0000, 1'b0);
    set_regs(32'hA000_0000);

    // 257 back-to-back packets from a fresh sequence counter.
    do_reset();
    base_cnt = cmpl_cnt;
    for (int k = 0; k < 257; k++) begin
      trigger(1'b0);
      recv_pkt(8'(k), 32'hA000_0000, 1'b0);
    end
    check("cmpl_count_257", 64'(cmpl_cnt - base_cnt), 64'd257);

    // Reset while lane 10 is on the bus.
    trigger(1'b0);
    up_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("mid_word10", 64'(up_data), 64'hA000_000A);
    reset_poweron = 1'b1;
    #1;
    check("async_valid", 64'(up_valid), 64'd0);
    check("async_data", 64'(up_data), 64'd0);
    check("async_eop", 64'(up_eop), 64'd0);
    tick();
    reset_poweron = 1'b0;
    up_ready = 1'b0;
    tick();
    trigger(1'b0);
    recv_pkt(8'd0, 32'hA000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
